regfile_scoreboard: RTL and testbench
=====================================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter DW, default 32: data width in bits.
REQ-002 SHALL have parameter AW, default 5: address width; depth = 2**AW entries.
REQ-003 SHALL have parameter NR, default 2: number of read ports, range 1..4.
REQ-004 SHALL have port clk  input  1: clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port ra  input  NR*AW: read addresses; port k occupies bits [k*AW +: AW].
REQ-007 SHALL have port rd  output  NR*DW: read data; port k occupies bits [k*DW +: DW].
REQ-008 SHALL have port rbusy  output  NR: port k is 1 when entry ra[k] has an outstanding reservation.
REQ-009 SHALL have port we  input  1: write enable.
REQ-010 SHALL have port wa  input  AW: write address.
REQ-011 SHALL have port wd  input  DW: write data.
REQ-012 SHALL have port wpc  input  32: PC of the writing instruction; used for trace only.
REQ-013 SHALL have port rsv_en  input  1: reserve request; marks a destination as pending.
REQ-014 SHALL have port rsv_a  input  AW: address to reserve.
REQ-015 SHALL have port trc_vld  output  1: registered trace strobe for an accepted write.
REQ-016 SHALL have port trc_pc  output  32: registered copy of wpc for the traced write.
REQ-017 SHALL have port trc_a  output  AW: registered copy of wa for the traced write.
REQ-018 SHALL have port trc_d  output  DW: registered copy of wd for the traced write.

Function
REQ-019 Entry 0 SHALL read as all zeros; writes and reservations to address 0 SHALL be ignored.
REQ-020 Reads SHALL be combinational: rd[k] = entry[ra[k]].
REQ-021 Write-through bypass: when we=1, wa!=0 and wa==ra[k], rd[k] SHALL equal wd in the same cycle.
REQ-022 A write is accepted when we=1 and wa!=0; the entry SHALL update at the next rising edge.
REQ-023 Each entry 1..2**AW-1 SHALL have a busy bit; when rsv_en=1 and rsv_a!=0, busy[rsv_a] SHALL be set at the next edge.
REQ-024 An accepted write SHALL clear busy[wa] at the next edge.
REQ-025 Reserve and write to the same address in the same cycle: busy SHALL remain 1, because the newer reservation wins; the data SHALL still be written.
REQ-026 rbusy[k] SHALL equal busy[ra[k]] AND NOT (accepted write with wa==ra[k]), so a bypassed read is never reported busy.
REQ-027 A write to an entry whose busy bit is 0 SHALL be accepted normally, with busy staying 0.
REQ-028 Trace: trc_vld SHALL be 1 exactly one cycle after each accepted write, with trc_pc/trc_a/trc_d holding that cycle's wpc/wa/wd; otherwise trc_vld=0 and the data fields hold their last value.
REQ-029 Multiple read ports addressing the same entry SHALL return identical rd and rbusy values.

Reset
REQ-030 When reset=1 at a rising edge, all entries, all busy bits, trc_vld, trc_pc, trc_a and trc_d SHALL become 0.
REQ-031 reset SHALL take priority over a simultaneous write or reservation, including mid-operation while reservations are outstanding.
REQ-032 While reset=1, rd SHALL still reflect the REQ-020/021 read paths; no trace SHALL be emitted for writes in the reset cycle.

Structure
REQ-033 The default DW, AW and NR values and the trace record field widths SHALL live in the shared CPU package.
REQ-034 The per-port read/bypass/busy path SHALL be one sub-module, regfile_rdport, instantiated NR times in a generate loop.
REQ-035 Storage and the busy vector SHALL be plain flops with no vendor RAM primitive.

Verification
REQ-036 Write then read: reset; we=1, wa=5, wd=0x12345678, wpc=0x3000; next cycle ra[0]=5 -> rd[0]=0x12345678, trc_vld=1, trc_pc=0x3000, trc_a=5.
REQ-037 Bypass: we=1, wa=7, wd=0xDEADBEEF with ra[1]=7 in the same cycle -> rd[1]=0xDEADBEEF and rbusy[1]=0 combinationally.
REQ-038 Zero register: we=1, wa=0, wd=0xFFFFFFFF; rsv_en=1, rsv_a=0 -> rd=0 and rbusy=0 for ra=0, and trc_vld stays 0.
REQ-039 Scoreboard: rsv_a=9 -> rbusy=1 for ra=9; one cycle with we=1, wa=9 and rsv_en=1, rsv_a=9 -> busy stays 1; a later write with wa=9 alone -> busy 0.
REQ-040 Reset mid-operation: reserve entries 3 and 4 and write 0xAA to entry 3; assert reset with we=1, wa=4 -> all entries read 0, all rbusy=0, trc_vld=0 after the edge.
REQ-041 Parameter sweep: NR=4, AW=3, DW=16 -> all four read ports read the same entry 6 written with 0xBEEF and return identical values.

Source files
------------

// File: rtl/regfile_scoreboard_pkg.sv
// rtl/regfile_scoreboard_pkg.sv - shared CPU defaults for the register file and its trace record
package regfile_scoreboard_pkg;

  // Default register-file geometry
  localparam int RF_DW = 32;
  localparam int RF_AW = 5;
  localparam int RF_NR = 2;

  // Trace record field widths; address and data fields follow AW and DW
  localparam int TRC_PC_W  = 32;
  localparam int TRC_VLD_W = 1;

endpackage

// File: rtl/regfile_rdport.sv
// rtl/regfile_rdport.sv - one combinational read port with write-through bypass and busy report
module regfile_rdport
  import regfile_scoreboard_pkg::*;
#(
  parameter int DW    = RF_DW,
  parameter int AW    = RF_AW,
  parameter int DEPTH = 2**AW
) (
  input  logic [AW-1:0]    ra_i,
  input  logic [DW-1:0]    entries_i [DEPTH],
  input  logic [DEPTH-1:0] busy_i,
  input  logic             wr_acc_i,
  input  logic [AW-1:0]    wa_i,
  input  logic [DW-1:0]    wd_i,
  output logic [DW-1:0]    rd_o,
  output logic             rbusy_o
);

  logic hit;

  // wr_acc_i already excludes address 0, so entry 0 can never be bypassed
  assign hit = wr_acc_i && (wa_i == ra_i);

  // A bypassed read sees the incoming data and is never reported busy,
  // because the write resolves the pending reservation
  assign rd_o    = hit ? wd_i : entries_i[ra_i];
  assign rbusy_o = busy_i[ra_i] & ~hit;

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - flop register file with per-entry reservation busy bits and write trace
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int DW = RF_DW,
  parameter int AW = RF_AW,
  parameter int NR = RF_NR
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NR*AW-1:0]    ra,
  output logic [NR*DW-1:0]    rd,
  output logic [NR-1:0]       rbusy,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [DW-1:0]       wd,
  input  logic [TRC_PC_W-1:0] wpc,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_a,
  output logic                trc_vld,
  output logic [TRC_PC_W-1:0] trc_pc,
  output logic [AW-1:0]       trc_a,
  output logic [DW-1:0]       trc_d
);

  localparam int DEPTH = 2**AW;

  // Entry 0 has no storage; it is hard-wired to zero in the read view
  logic [DW-1:0]       mem_q [1:DEPTH-1];
  logic [DEPTH-1:1]    busy_q;
  logic [DW-1:0]       entries [DEPTH];
  logic [DEPTH-1:0]    busy_view;
  logic                wr_acc;
  logic                rsv_acc;

  logic                trc_vld_q, trc_vld_d;
  logic [TRC_PC_W-1:0] trc_pc_q, trc_pc_d;
  logic [AW-1:0]       trc_a_q, trc_a_d;
  logic [DW-1:0]       trc_d_q, trc_d_d;

  assign wr_acc    = we && (wa != '0);
  assign rsv_acc   = rsv_en && (rsv_a != '0);
  assign busy_view = {busy_q, 1'b0};

  // Present storage as a full-depth array with entry 0 reading as zero
  always_comb begin
    entries[0] = '0;
    for (int i = 1; i < DEPTH; i++) begin
      entries[i] = mem_q[i];
    end
  end

  // Entry and busy-bit update; a same-cycle reservation overrides the write's clear
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (wr_acc && (wa == AW'(i))) begin
          mem_q[i] <= wd;
        end
        if (rsv_acc && (rsv_a == AW'(i))) begin
          busy_q[i] <= 1'b1;
        end else if (wr_acc && (wa == AW'(i))) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  // Trace next state: strobe follows accepted writes, fields hold otherwise
  always_comb begin
    trc_vld_d = wr_acc;
    trc_pc_d  = trc_pc_q;
    trc_a_d   = trc_a_q;
    trc_d_d   = trc_d_q;
    if (wr_acc) begin
      trc_pc_d = wpc;
      trc_a_d  = wa;
      trc_d_d  = wd;
    end
  end

  // Trace registers; reset suppresses the trace of a write in the reset cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      trc_vld_q <= 1'b0;
      trc_pc_q  <= '0;
      trc_a_q   <= '0;
      trc_d_q   <= '0;
    end else begin
      trc_vld_q <= trc_vld_d;
      trc_pc_q  <= trc_pc_d;
      trc_a_q   <= trc_a_d;
      trc_d_q   <= trc_d_d;
    end
  end

  assign trc_vld = trc_vld_q;
  assign trc_pc  = trc_pc_q;
  assign trc_a   = trc_a_q;
  assign trc_d   = trc_d_q;

  // One read/bypass/busy path per read port
  for (genvar k = 0; k < NR; k++) begin : g_rdport
    regfile_rdport #(
      .DW    (DW),
      .AW    (AW),
      .DEPTH (DEPTH)
    ) u_rdport (
      .ra_i      (ra[k*AW +: AW]),
      .entries_i (entries),
      .busy_i    (busy_view),
      .wr_acc_i  (wr_acc),
      .wa_i      (wa),
      .wd_i      (wd),
      .rd_o      (rd[k*DW +: DW]),
      .rbusy_o   (rbusy[k])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        we, rsv_en;
  logic [4:0]  wa, rsv_a;
  logic [31:0] wd, wpc;
  logic [4:0]  ra_a [2];
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rbusy;
  logic        trc_vld;
  logic [31:0] trc_pc;
  logic [4:0]  trc_a;
  logic [31:0] trc_d;

  logic        we2;
  logic [2:0]  wa2;
  logic [15:0] wd2;
  logic [2:0]  ra2_a [4];
  logic [11:0] ra2;
  logic [63:0] rd2;
  logic [3:0]  rbusy2;
  logic        trc_vld2;
  logic [31:0] trc_pc2;
  logic [2:0]  trc_a2;
  logic [15:0] trc_d2;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: architectural register values, pending reservations, last trace record
  logic [31:0] m_mem  [32];
  bit          m_busy [32];
  logic        m_tv;
  logic [31:0] m_tpc, m_td;
  logic [4:0]  m_ta;

  assign ra  = {ra_a[1], ra_a[0]};
  assign ra2 = {ra2_a[3], ra2_a[2], ra2_a[1], ra2_a[0]};

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rbusy(rbusy),
    .we(we), .wa(wa), .wd(wd), .wpc(wpc), .rsv_en(rsv_en), .rsv_a(rsv_a),
    .trc_vld(trc_vld), .trc_pc(trc_pc), .trc_a(trc_a), .trc_d(trc_d)
  );

  regfile_scoreboard #(.DW(16), .AW(3), .NR(4)) dut2 (
    .clk(clk), .reset(reset), .ra(ra2), .rd(rd2), .rbusy(rbusy2),
    .we(we2), .wa(wa2), .wd(wd2), .wpc(32'h0), .rsv_en(1'b0), .rsv_a(3'd0),
    .trc_vld(trc_vld2), .trc_pc(trc_pc2), .trc_a(trc_a2), .trc_d(trc_d2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    we = 0; wa = 0; wd = 0; wpc = 0; rsv_en = 0; rsv_a = 0;
  endtask

  // Advance one clock and apply the architectural rules to the reference state
  task automatic cycle();
    @(posedge clk);
    #1;
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i] = 0; m_busy[i] = 0;
      end
      m_tv = 0; m_tpc = 0; m_ta = 0; m_td = 0;
    end else begin
      m_tv = 0;
      if (we && wa != 0) begin
        m_mem[wa] = wd; m_busy[wa] = 0;
        m_tv = 1; m_tpc = wpc; m_ta = wa; m_td = wd;
      end
      if (rsv_en && rsv_a != 0) m_busy[rsv_a] = 1;
    end
  endtask

  // Read ports as seen this cycle: stored value, or the write data when it targets the same entry
  task automatic check_reads(input string tag);
    #2;
    for (int k = 0; k < 2; k++) begin
      logic        hit;
      logic [31:0] e_rd;
      hit  = we && wa != 0 && wa == ra_a[k];
      e_rd = hit ? wd : m_mem[ra_a[k]];
      chk({tag, $sformatf(" rd[%0d]", k)}, rd[k*32 +: 32], e_rd);
      chk({tag, $sformatf(" rbusy[%0d]", k)}, rbusy[k], m_busy[ra_a[k]] && !hit);
    end
  endtask

  task automatic check_trace(input string tag);
    chk({tag, " trc_vld"}, trc_vld, m_tv);
    chk({tag, " trc_pc"}, trc_pc, m_tpc);
    chk({tag, " trc_a"}, trc_a, m_ta);
    chk({tag, " trc_d"}, trc_d, m_td);
  endtask

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    we2 = 0; wa2 = 0; wd2 = 0;
    for (int k = 0; k < 4; k++) ra2_a[k] = 0;
    ra_a[0] = 0; ra_a[1] = 0;
    reset = 1;
    cycle();
    reset = 0;

    // Reset state across every address
    for (int a = 0; a < 32; a += 2) begin
      ra_a[0] = 5'(a); ra_a[1] = 5'(a + 1);
      check_reads("reset_state");
    end
    check_trace("reset_state");

    // Write then read with trace
    ra_a[0] = 0; ra_a[1] = 0;
    we = 1; wa = 5; wd = 32'h12345678; wpc = 32'h3000;
    cycle();
    idle();
    ra_a[0] = 5;
    check_reads("wr_then_rd");
    chk("wr_then_rd rd0_const", rd[31:0], 32'h12345678);
    check_trace("wr_then_rd");
    chk("wr_then_rd trc_pc_const", trc_pc, 32'h3000);

    // Bypass on a reserved entry: data visible and not busy in the same cycle
    rsv_en = 1; rsv_a = 7;
    cycle();
    idle();
    ra_a[1] = 7;
    check_reads("rsv7");
    chk("rsv7 rbusy1_const", rbusy[1], 1'b1);
    we = 1; wa = 7; wd = 32'hDEADBEEF;
    check_reads("bypass");
    chk("bypass rd1_const", rd[63:32], 32'hDEADBEEF);
    chk("bypass rbusy1_const", rbusy[1], 1'b0);
    cycle();
    idle();

    // Zero register ignores writes and reservations
    ra_a[0] = 0; ra_a[1] = 0;
    we = 1; wa = 0; wd = 32'hFFFFFFFF; rsv_en = 1; rsv_a = 0;
    check_reads("zero_reg");
    cycle();
    idle();
    check_reads("zero_reg_after");
    chk("zero_reg trc_vld_const", trc_vld, 1'b0);

    // Reservation wins over a simultaneous write; a later lone write clears it
    rsv_en = 1; rsv_a = 9;
    cycle();
    idle();
    ra_a[0] = 9;
    check_reads("sb_rsv");
    chk("sb_rsv rbusy_const", rbusy[0], 1'b1);
    we = 1; wa = 9; wd = 32'h99; rsv_en = 1; rsv_a = 9;
    cycle();
    idle();
    check_reads("sb_both");
    chk("sb_both rbusy_const", rbusy[0], 1'b1);
    chk("sb_both rd_const", rd[31:0], 32'h99);
    we = 1; wa = 9; wd = 32'h9A;
    cycle();
    idle();
    check_reads("sb_clear");
    chk("sb_clear rbusy_const", rbusy[0], 1'b0);

    // Reset in the middle of outstanding reservations
    rsv_en = 1; rsv_a = 3;
    cycle();
    rsv_a = 4;
    cycle();
    idle();
    we = 1; wa = 3; wd = 32'hAA;
    cycle();
    idle();
    ra_a[0] = 3; ra_a[1] = 4;
    check_reads("pre_reset");
    reset = 1; we = 1; wa = 4; wd = 32'h55; rsv_en = 1; rsv_a = 5;
    check_reads("in_reset");
    cycle();
    reset = 0;
    idle();
    for (int a = 0; a < 32; a += 2) begin
      ra_a[0] = 5'(a); ra_a[1] = 5'(a + 1);
      check_reads("post_reset");
      chk("post_reset rbusy_const", rbusy, 2'b00);
    end
    check_trace("post_reset");

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      reset  = ($urandom_range(0, 59) == 0);
      we     = $urandom_range(0, 1);
      wa     = rnd_addr();
      wd     = $urandom;
      wpc    = $urandom;
      rsv_en = ($urandom_range(0, 2) == 0);
      rsv_a  = rnd_addr();
      ra_a[0] = rnd_addr();
      ra_a[1] = ($urandom_range(0, 3) == 0) ? ra_a[0] : rnd_addr();
      check_reads("rand");
      cycle();
      check_trace("rand");
    end
    reset = 0;
    idle();

    // Four-port narrow instance: every port reads the same entry
    we2 = 1; wa2 = 6; wd2 = 16'hBEEF;
    cycle();
    we2 = 0;
    for (int k = 0; k < 4; k++) ra2_a[k] = 6;
    #2;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("sweep rd[%0d]", k), rd2[k*16 +: 16], 16'hBEEF);
    end
    chk("sweep rbusy", rbusy2, 4'b0000);
    chk("sweep trc_vld", trc_vld2, 1'b1);
    chk("sweep trc_a", trc_a2, 3'd6);
    chk("sweep trc_d", trc_d2, 16'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
